upscale: RTL and testbench

//  Pulse multiplier, the inverse of the edge prescaler: each rising edge on
//  din emits a burst of `up` single-cycle dout pulses spaced `gap` low cycles.

---
 rtl/upscale.sv | 128 ++++++++++++
 tb/tb_upscale.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/upscale.sv
// Pulse multiplier: each synchronised rising edge on din emits a burst of `up`
// single-cycle dout pulses separated by `gap` low cycles, with a 1-deep retrigger queue.
module upscale #(
    parameter int DATA_W = 16,
    parameter int GAP_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic [DATA_W-1:0] up,
    input  logic [GAP_W-1:0]  gap,
    output logic              dout,
    output logic              busy,
    output logic              overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic              s1_q, s1_d, s2_q, s2_d;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] pcnt_q, pcnt_d, up_l_q, up_l_d;
    logic [GAP_W-1:0]  gcnt_q, gcnt_d, gap_l_q, gap_l_d;
    logic              pending_q, pending_d;
    logic              dout_q, dout_d, busy_q, busy_d, overflow_q, overflow_d;

    logic              trig;
    logic              last_pulse;
    logic              gap_done;
    logic [GAP_W-1:0]  gap_eff;

    assign trig       = s1_q & ~s2_q;
    assign gap_eff    = (gap == '0) ? GAP_W'(1) : gap;
    assign last_pulse = (pcnt_q == up_l_q - DATA_W'(1));
    assign gap_done   = (gcnt_q == gap_l_q - GAP_W'(1));

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
        s1_d       = din;
        s2_d       = s1_q;
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        gcnt_d     = gcnt_q;
        up_l_d     = up_l_q;
        gap_l_d    = gap_l_q;
        pending_d  = pending_q;
        overflow_d = 1'b0;

        // Retrigger while busy queues one burst; a further edge is dropped.
        if (state_q != S_IDLE && trig) begin
            if (pending_q) overflow_d = 1'b1;
            else           pending_d  = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (trig && up != '0) begin
                    state_d = S_PULSE;
                    up_l_d  = up;
                    gap_l_d = gap_eff;
                    pcnt_d  = '0;
                end
            end
            S_PULSE: begin
                if (last_pulse) begin
                    pending_d = 1'b0;
                    // An edge landing in this very cycle counts as pending too.
                    if ((pending_q || trig) && up != '0) begin
                        state_d = S_GAP;
                        up_l_d  = up;
                        gap_l_d = gap_eff;
                        pcnt_d  = '0;
                        gcnt_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_GAP;
                    pcnt_d  = pcnt_q + DATA_W'(1);
                    gcnt_d  = '0;
                end
            end
            S_GAP: begin
                if (gap_done) state_d = S_PULSE;
                else          gcnt_d  = gcnt_q + GAP_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        dout_d = (state_d == S_PULSE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            state_q    <= S_IDLE;
            pcnt_q     <= '0;
            gcnt_q     <= '0;
            up_l_q     <= '0;
            gap_l_q    <= '0;
            pending_q  <= 1'b0;
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            gcnt_q     <= gcnt_d;
            up_l_q     <= up_l_d;
            gap_l_q    <= gap_l_d;
            pending_q  <= pending_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign dout     = dout_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_upscale.sv
// Directed bench for upscale: table of single-burst vectors plus hand sequences
// for disabled mode, retrigger/overflow, mid-burst parameter change and reset.
module tb_upscale;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic [15:0] up = '0;
    logic [15:0] gap = '0;
    logic        dout, busy, overflow;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    upscale #(.DATA_W(16), .GAP_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .up       (up),
        .gap      (gap),
        .dout     (dout),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int up;
        int gap;
        int total;
        int period;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Walks ncyc negedges. Trigger at iteration 0 (t0 = next posedge), optional
    // extra triggers at tr2/tr3; expects `total` pulses at t0+1+k*period.
    task automatic walk(input string name, input int tr2, input int tr3, input int ncyc,
                        input int total, input int period, input int exp_ovf,
                        input int chg_i, input int chg_up);
        int t0;
        int k;
        int ovf;
        int exp_d;
        int exp_b;
        t0  = 0;
        ovf = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i == 0) t0 = cyc + 1;
            k = cyc - t0 - 1;
            exp_d = (total > 0 && k >= 0 && (k % period) == 0 && (k / period) < total) ? 1 : 0;
            exp_b = (total > 0 && k >= 0 && k <= (total - 1) * period) ? 1 : 0;
            check({name, ".dout"}, int'(dout), exp_d);
            check({name, ".busy"}, int'(busy), exp_b);
            ovf += int'(overflow);
            if (i == chg_i) up = 16'(chg_up);
            din = (i < 2) || (tr2 >= 0 && i >= tr2 && i < tr2 + 2)
                          || (tr3 >= 0 && i >= tr3 && i < tr3 + 2);
        end
        din = 1'b0;
        check({name, ".ovf_count"}, ovf, exp_ovf);
    endtask

    initial begin
        vec_t vecs[6];
        int   c_rel;
        int   seen;

        vecs[0] = '{up: 3, gap: 2, total: 3, period: 3};
        vecs[1] = '{up: 1, gap: 0, total: 1, period: 2};
        vecs[2] = '{up: 4, gap: 0, total: 4, period: 2};
        vecs[3] = '{up: 2, gap: 5, total: 2, period: 6};
        vecs[4] = '{up: 6, gap: 1, total: 6, period: 2};
        vecs[5] = '{up: 1, gap: 7, total: 1, period: 8};

        repeat (3) @(negedge clk);
        check("reset.dout", int'(dout), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.ovf",  int'(overflow), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[v]) begin
            up  = 16'(vecs[v].up);
            gap = 16'(vecs[v].gap);
            walk($sformatf("vec%0d", v), -1, -1, 6 + vecs[v].total * vecs[v].period,
                 vecs[v].total, vecs[v].period, 0, -1, 0);
        end

        // Disabled block: ten edges produce nothing.
        up  = 16'd0;
        gap = 16'd2;
        for (int n = 0; n < 10; n++) walk("disabled", -1, -1, 8, 0, 1, 0, -1, 0);

        // Retrigger mid-burst, then a third edge while pending -> one overflow.
        up  = 16'd4;
        gap = 16'd3;
        walk("retrig", 5, 9, 40, 8, 4, 1, -1, 0);

        // up changed mid-burst only affects the queued burst: 5 + 2 pulses.
        up  = 16'd5;
        gap = 16'd1;
        walk("relatch", 3, -1, 20, 7, 2, 0, 5, 2);

        // Reset during a gap aborts the burst asynchronously.
        up  = 16'd3;
        gap = 16'd4;
        @(negedge clk);
        din   = 1'b1;
        c_rel = cyc;
        repeat (2) @(negedge clk);
        din = 1'b0;
        while (cyc < c_rel + 8) @(negedge clk);
        check("rst_mid.busy_before", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid.dout", int'(dout), 0);
        check("rst_mid.busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (20) begin
            @(negedge clk);
            seen += int'(dout) + int'(busy);
        end
        check("rst_mid.quiet_after", seen, 0);

        // din held high across reset release is one rising edge.
        up  = 16'd1;
        gap = 16'd1;
        rst_n = 1'b0;
        din   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        c_rel = cyc;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_hold.dout", int'(dout), (cyc == c_rel + 2) ? 1 : 0);
        end
        din = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
